// File: rtl/pc_pkg.sv
// Shared types and default constants for the program-counter unit.
// The state enumeration is shared by the unit and anything that inspects it.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_e;

  localparam int unsigned PC_WIDTH     = 16;
  localparam logic [15:0] PC_RESET_VEC = 16'h0800;
  localparam logic [15:0] PC_EXC_VEC   = 16'h0002;
  localparam int unsigned PC_STEP      = 2;

endpackage

// File: rtl/pc_unit_init_if.sv
// Control/observation bundle for pc_unit_init.
// epc exists only when PC_EPC_EN is defined.
interface pc_unit_init_if #(
  parameter int unsigned WIDTH = 16
);

  logic             stall;
  logic             ld_en;
  logic [WIDTH-1:0] ld_addr;
  logic             halt;
  logic             resume;
  logic             exc;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_seq;
  logic             running;
  logic             wrap;
`ifdef PC_EPC_EN
  logic [WIDTH-1:0] epc;

  modport master (
    output stall, ld_en, ld_addr, halt, resume, exc,
    input  pc, pc_seq, running, wrap, epc
  );

  modport slave (
    input  stall, ld_en, ld_addr, halt, resume, exc,
    output pc, pc_seq, running, wrap, epc
  );
`else
  modport master (
    output stall, ld_en, ld_addr, halt, resume, exc,
    input  pc, pc_seq, running, wrap
  );

  modport slave (
    input  stall, ld_en, ld_addr, halt, resume, exc,
    output pc, pc_seq, running, wrap
  );
`endif

endinterface

// File: rtl/pc_reg.sv
// WIDTH-wide register with load enable and asynchronous active-low preset.
module pc_reg #(
  parameter int unsigned      WIDTH  = 16,
  parameter logic [WIDTH-1:0] PRESET = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= PRESET;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_unit_init.sv
// Program counter with BOOT/RUN/HALTED control, redirects, exceptions and wrap flag.
// Optional macro PC_EPC_EN adds the saved exception return address (epc).
module pc_unit_init
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH     = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC),
  parameter int unsigned      STEP      = PC_STEP,
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(PC_EXC_VEC)
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_unit_init_if.slave  bus
);

  localparam int unsigned SUM_W = WIDTH + 1;

  pc_state_e        state_q;
  pc_state_e        state_d;
  logic             running_q;
  logic             wrap_q;
  logic             wrap_d;
  logic             pc_ld;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_q;
  logic             epc_ld;
  logic [SUM_W-1:0] seq_full;

  // Sequential successor with carry-out to detect overflow.
  assign seq_full = {1'b0, pc_q} + SUM_W'(STEP);

  always_comb begin
    state_d = state_q;
    pc_ld   = 1'b0;
    pc_d    = pc_q;
    wrap_d  = 1'b0;
    epc_ld  = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (bus.exc) begin
          pc_ld  = 1'b1;
          pc_d   = EXC_VEC;
          epc_ld = 1'b1;
        end else if (bus.ld_en) begin
          pc_ld = 1'b1;
          pc_d  = bus.ld_addr;
        end else if (bus.halt) begin
          state_d = HALTED;
        end else if (!bus.stall) begin
          pc_ld  = 1'b1;
          pc_d   = seq_full[WIDTH-1:0];
          wrap_d = seq_full[WIDTH];
        end
      end
      HALTED: begin
        // resume wins over a simultaneous halt or ld_en; pc is left untouched
        if (bus.exc) begin
          state_d = RUN;
          pc_ld   = 1'b1;
          pc_d    = EXC_VEC;
          epc_ld  = 1'b1;
        end else if (bus.resume) begin
          state_d = RUN;
        end else if (bus.ld_en) begin
          pc_ld = 1'b1;
          pc_d  = bus.ld_addr;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BOOT;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == RUN);
      wrap_q    <= wrap_d;
    end
  end

  pc_reg #(
    .WIDTH  (WIDTH),
    .PRESET (RESET_VEC)
  ) u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (pc_ld),
    .d     (pc_d),
    .q     (pc_q)
  );

`ifdef PC_EPC_EN
  logic [WIDTH-1:0] epc_q;

  // Captures the pc current at the moment an exception is accepted.
  pc_reg #(
    .WIDTH  (WIDTH),
    .PRESET ('0)
  ) u_epc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (epc_ld),
    .d     (pc_q),
    .q     (epc_q)
  );

  assign bus.epc = epc_q;
`else
  logic unused_epc_ld;
  assign unused_epc_ld = epc_ld;
`endif

  assign bus.pc      = pc_q;
  assign bus.pc_seq  = seq_full[WIDTH-1:0];
  assign bus.running = running_q;
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_pc_unit_init.sv
// Bench for pc_unit_init: directed scenarios plus random stimulus against a reference model.
// Checks epc as well when PC_EPC_EN is defined.
module tb_pc_unit_init;

  localparam int unsigned W      = 16;
  localparam int          MOD    = 65536;
  localparam int          RSTV   = 'h0800;
  localparam int          EXCV   = 'h0002;
  localparam int          STEPV  = 2;
  localparam int          M_BOOT = 0;
  localparam int          M_RUN  = 1;
  localparam int          M_HALT = 2;

  logic clk;
  logic rst_n;

  pc_unit_init_if #(.WIDTH(W)) bus ();

  pc_unit_init dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // reference model state
  int m_state;
  int m_pc;
  int m_wrap;
  int m_epc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_BOOT;
    m_pc    = RSTV;
    m_wrap  = 0;
    m_epc   = 0;
  endtask

  task automatic model_step();
    int s;
    m_wrap = 0;
    case (m_state)
      M_BOOT: m_state = M_RUN;
      M_RUN: begin
        if (bus.exc) begin
          m_epc = m_pc;
          m_pc  = EXCV;
        end else if (bus.ld_en) begin
          m_pc = int'(bus.ld_addr);
        end else if (bus.halt) begin
          m_state = M_HALT;
        end else if (!bus.stall) begin
          s      = m_pc + STEPV;
          m_wrap = (s >= MOD) ? 1 : 0;
          m_pc   = s % MOD;
        end
      end
      default: begin
        if (bus.exc) begin
          m_epc   = m_pc;
          m_pc    = EXCV;
          m_state = M_RUN;
        end else if (bus.resume) begin
          m_state = M_RUN;
        end else if (bus.ld_en) begin
          m_pc = int'(bus.ld_addr);
        end
      end
    endcase
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"},      32'(bus.pc),      32'(m_pc));
    check({tag, ".pc_seq"},  32'(bus.pc_seq),  32'((m_pc + STEPV) % MOD));
    check({tag, ".running"}, 32'(bus.running), 32'(m_state == M_RUN));
    check({tag, ".wrap"},    32'(bus.wrap),    32'(m_wrap));
`ifdef PC_EPC_EN
    check({tag, ".epc"},     32'(bus.epc),     32'(m_epc));
`endif
  endtask

  task automatic drive(input logic st, input logic ld, input logic [W-1:0] a,
                       input logic h, input logic r, input logic e);
    bus.stall   = st;
    bus.ld_en   = ld;
    bus.ld_addr = a;
    bus.halt    = h;
    bus.resume  = r;
    bus.exc     = e;
  endtask

  // One clock: DUT and model consume the same inputs, then compare #1 after the edge.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_model(tag);
  endtask

  task automatic apply(input string tag, input logic st, input logic ld, input logic [W-1:0] a,
                       input logic h, input logic r, input logic e);
    drive(st, ld, a, h, r, e);
    cycle(tag);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #12;
    check_model("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // free run out of reset
    cycle("boot");
    check("boot_pc", 32'(bus.pc), 32'h0800);
    cycle("run1");
    check("run1_pc", 32'(bus.pc), 32'h0802);
    cycle("run2");
    check("run2_pc", 32'(bus.pc), 32'h0804);
    cycle("run3");
    check("run3_pc", 32'(bus.pc), 32'h0806);

    // halt / load while halted / resume
    apply("halt", 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("halt_run", 32'(bus.running), 32'h0);
    check("halt_pc",  32'(bus.pc), 32'h0806);
    apply("hld", 1'b0, 1'b1, 16'h2000, 1'b0, 1'b0, 1'b0);
    check("hld_pc",  32'(bus.pc), 32'h2000);
    check("hld_run", 32'(bus.running), 32'h0);
    apply("hold", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    apply("resume", 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("resume_run", 32'(bus.running), 32'h1);
    check("resume_pc",  32'(bus.pc), 32'h2000);
    apply("post_resume", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("post_resume_pc", 32'(bus.pc), 32'h2002);

    // stall/load collision, then stall alone
    apply("stld", 1'b1, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0);
    check("stld_pc", 32'(bus.pc), 32'h1234);
    apply("stall", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("stall_pc", 32'(bus.pc), 32'h1234);

    // exception beats a simultaneous load
    apply("ld_a00", 1'b0, 1'b1, 16'h0A00, 1'b0, 1'b0, 1'b0);
    apply("exc", 1'b0, 1'b1, 16'h4444, 1'b0, 1'b0, 1'b1);
    check("exc_pc", 32'(bus.pc), 32'h0002);
`ifdef PC_EPC_EN
    check("exc_epc", 32'(bus.epc), 32'h0A00);
`endif

    // exception from HALTED re-enters RUN
    apply("halt2", 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    apply("hexc", 1'b0, 1'b1, 16'h5555, 1'b0, 1'b1, 1'b1);
    check("hexc_run", 32'(bus.running), 32'h1);

    // increment overflow
    apply("ld_fffe", 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    check("ld_fffe_wrap", 32'(bus.wrap), 32'h0);
    apply("wrap", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("wrap_pc",  32'(bus.pc), 32'h0000);
    check("wrap_set", 32'(bus.wrap), 32'h1);
    apply("ld_0", 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("ld_0_wrap", 32'(bus.wrap), 32'h0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic st, ld, h, r, e;
      logic [W-1:0] a;
      st = ($urandom_range(0, 99) < 20);
      ld = ($urandom_range(0, 99) < 12);
      h  = ($urandom_range(0, 99) < 8);
      r  = ($urandom_range(0, 99) < 25);
      e  = ($urandom_range(0, 99) < 4);
      a  = ($urandom_range(0, 3) == 0) ? W'(16'hFFF0 + 16'($urandom_range(0, 15)))
                                       : W'($urandom);
      if (m_state == M_HALT && r) ld = 1'b0;
      apply("rnd", st, ld, a, h, r, e);
    end

    // asynchronous reset while halted, mid-cycle
    apply("pre_halt", 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    apply("halt3", 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("halt3_run", 32'(bus.running), 32'h0);
    drive(1'b0, 1'b1, 16'h7777, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_model("async_rst");
    check("async_rst_pc", 32'(bus.pc), 32'h0800);
    #3;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    cycle("rboot");
    check("rboot_pc", 32'(bus.pc), 32'h0800);
    cycle("rrun");
    check("rrun_pc", 32'(bus.pc), 32'h0802);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
